// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and command sequencer for a 32x8 single-port RAM.
// Supports exclusive lock ownership and routes read data back to the issuing port.
module ram_arbiter #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH:0]   p0_addr,
  input  logic [DATA_WIDTH:0]   p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH:0]   p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH:0]   p1_addr,
  input  logic [DATA_WIDTH:0]   p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH:0]   p1_rdata,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic [DATA_WIDTH:0]   ram_data_in,
  input  logic [DATA_WIDTH:0]   ram_data_out
);

  typedef enum logic [1:0] {
    ST_OPEN  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                last_port_r;

  logic                gnt0_s;
  logic                gnt1_s;
  logic                acc0_s;
  logic                acc1_s;
  logic                acc_any_s;
  logic                acc_port_s;
  logic                acc_we_s;
  logic                acc_lock_s;
  logic [ADDR_WIDTH:0] acc_addr_s;
  logic [DATA_WIDTH:0] acc_wdata_s;

  // Read tag pipeline: stage 1 aligns with the RAM strobe, stage 2 with ram_data_out.
  logic                tag1_valid_r;
  logic                tag1_port_r;
  logic                tag2_valid_r;
  logic                tag2_port_r;

  // State register and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_OPEN;
      last_port_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (acc_any_s) begin
        last_port_r <= acc_port_s;
      end
    end
  end

  // Next-state: the accepted command's lock bit decides ownership
  always_comb begin
    state_next_s = ST_OPEN;
    if (acc_any_s) begin
      if (acc_lock_s) begin
        state_next_s = acc_port_s ? ST_LOCK1 : ST_LOCK0;
      end else begin
        state_next_s = ST_OPEN;
      end
    end else begin
      case (state_r)
        ST_OPEN:  state_next_s = ST_OPEN;
        ST_LOCK0: state_next_s = ST_LOCK0;
        ST_LOCK1: state_next_s = ST_LOCK1;
        default:  state_next_s = ST_OPEN;
      endcase
    end
  end

  // Grant outputs; on a tie the port not accepted last wins
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        ST_OPEN: begin
          if (p0_req && p1_req) begin
            gnt0_s = last_port_r;
            gnt1_s = ~last_port_r;
          end else begin
            gnt0_s = p0_req;
            gnt1_s = p1_req;
          end
        end
        ST_LOCK0: gnt0_s = p0_req;
        ST_LOCK1: gnt1_s = p1_req;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign p0_gnt    = gnt0_s;
  assign p1_gnt    = gnt1_s;
  assign acc0_s    = p0_req & gnt0_s;
  assign acc1_s    = p1_req & gnt1_s;
  assign acc_any_s = acc0_s | acc1_s;

  // Select the fields of the single accepted command
  always_comb begin
    acc_port_s  = acc1_s;
    if (acc1_s) begin
      acc_we_s    = p1_we;
      acc_lock_s  = p1_lock;
      acc_addr_s  = p1_addr;
      acc_wdata_s = p1_wdata;
    end else begin
      acc_we_s    = p0_we;
      acc_lock_s  = p0_lock;
      acc_addr_s  = p0_addr;
      acc_wdata_s = p0_wdata;
    end
  end

  // RAM command register; address and write data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rd_en   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      ram_rd_en <= acc_any_s & ~acc_we_s;
      ram_wr_en <= acc_any_s & acc_we_s;
      if (acc_any_s) begin
        ram_addr <= acc_addr_s;
      end
      if (acc_any_s && acc_we_s) begin
        ram_data_in <= acc_wdata_s;
      end
    end
  end

  // Tag pipeline and read-data return to the issuing port
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_valid_r <= 1'b0;
      tag1_port_r  <= 1'b0;
      tag2_valid_r <= 1'b0;
      tag2_port_r  <= 1'b0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      tag1_valid_r <= acc_any_s & ~acc_we_s;
      tag1_port_r  <= acc_port_s;
      tag2_valid_r <= tag1_valid_r;
      tag2_port_r  <= tag1_port_r;
      p0_rvalid    <= tag2_valid_r & ~tag2_port_r;
      p1_rvalid    <= tag2_valid_r & tag2_port_r;
      if (tag2_valid_r && !tag2_port_r) begin
        p0_rdata <= ram_data_out;
      end
      if (tag2_valid_r && tag2_port_r) begin
        p1_rdata <= ram_data_out;
      end
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the 32x8 single-port RAM. It accepts read/write commands from two independent requesters over a valid/grant handshake and drives the RAM's rd_en/wr_en/addr/data_in pins one command per cycle. It returns read data from data_out to the issuing requester. It also supports a lock, so one requester can own the RAM for an uninterrupted sequence (e.g. read-modify-write). The block sits between the requester logic and the RAM interface, on the same clk/rst.

## Interface
- DATA_WIDTH, default 7: MSB index of data buses; data is DATA_WIDTH+1 bits wide.
- ADDR_WIDTH, default 4: MSB index of address buses; 32 words.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- pN_req  in  1  command valid, port N (N = 0, 1).
- pN_we  in  1  1 = write, 0 = read.
- pN_lock  in  1  request/keep exclusive ownership after this command.
- pN_addr  in  ADDR_WIDTH+1  word address.
- pN_wdata  in  DATA_WIDTH+1  write data.
- pN_gnt  out  1  combinational; command accepted at the edge where req & gnt.
- pN_rvalid  out  1  registered, one-cycle read-data strobe.
- pN_rdata  out  DATA_WIDTH+1  registered read data; holds its value between strobes.
- ram_rd_en, ram_wr_en  out  1  registered RAM strobes.
- ram_addr  out  ADDR_WIDTH+1  registered RAM address.
- ram_data_in  out  DATA_WIDTH+1  registered RAM write data.
- ram_data_out  in  DATA_WIDTH+1  RAM read data, valid the cycle after RAM samples rd_en.

## Operation
- Requester holds req and its fields stable until it samples gnt=1. It may present its next command in the following cycle.
- States: OPEN, LOCK0, LOCK1.
  - OPEN: round-robin. When both ports request, the port not accepted last wins. When one port requests, it wins. last_port resets to 1, so port 0 wins the first tie.
  - LOCKn: only port n can be granted. The other port's gnt = 0 regardless of its req.
  - An accepted command with lock=1 moves to (or stays in) LOCKn for the accepting port n.
  - An accepted command with lock=0 from the owner returns to OPEN.
  - No timeout.
- On acceptance, the next edge registers the command onto the ram_* outputs: ram_wr_en = we, ram_rd_en = ~we. ram_data_in gets wdata on writes and holds its old value on reads.
- When no command is accepted, ram_rd_en = ram_wr_en = 0; ram_addr and ram_data_in hold.
- Never assert ram_rd_en and ram_wr_en together.
- Read tag pipeline:
  - A 2-stage shift register tracks {valid, port} for each issued read.
  - At stage 2, ram_data_out is captured into pN_rdata of the tagged port, and pN_rvalid pulses.
  - The other port's rdata/rvalid are untouched.
- RAM commands issue in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- gnt is forced to 0 while rst = 1.

## Timing
- Edge E0: req & gnt sampled, command accepted.
- Cycle after E0: ram_* outputs carry the command.
- Edge E1: RAM samples the command; a write completes here.
- Edge E2: read data captured. pN_rvalid is high for the cycle after E2 (read latency 2 cycles from acceptance).
- Throughput: one command per cycle, back-to-back, from either port or alternating.
- Reset values:
  - ram_rd_en = 0, ram_wr_en = 0, ram_addr = 0, ram_data_in = 0.
  - p0/p1_rvalid = 0, p0/p1_rdata = 0.
  - State = OPEN, last_port = 1, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped (no rvalid after reset) and any lock is released.
- Simultaneous events:
  - Port 0 and port 1 request in OPEN: exactly one gnt.
  - Owner releases the lock and the other port requests in the same cycle: the other port is first granted in the cycle after release.

## Test plan
- Reset, then p0 writes addr 5 = 0xA5 -> p0_gnt high that cycle; next cycle ram_wr_en = 1, ram_addr = 5, ram_data_in = 0xA5; rd_en stays 0.
- p0 reads addr 5 after that write -> ram_rd_en pulses the cycle after acceptance; p0_rvalid = 1 with p0_rdata = 0xA5 two cycles after acceptance; p1_rvalid stays 0.
- Both ports hold continuous reads (p0 addr 1, p1 addr 2) after reset -> grants alternate p0, p1, p0, ...; ram_addr sequence 1, 2, 1, 2; each port's rvalid carries its own data.
- p1 issues read addr 3 with lock=1, then write addr 3 = 0x3C with lock=0, while p0 requests continuously -> p0_gnt = 0 throughout the lock; p0 is granted the cycle after p1's unlocking write is accepted.
- Back-to-back write addr 31 = 0xFF then read addr 31 from one port -> rdata = 0xFF; addr 31 ↔ 0 boundary exercised.
- Assert rst one cycle after a read is accepted -> no rvalid ever appears for that read; all outputs at reset values; after reset a p0/p1 tie grants p0.
